// File: rtl/closest_hit_collector_if.sv
// Handshake and record bundle for the closest-hit collector.
// The slave modport is the collector side; the master modport is the traversal/shader side.
interface closest_hit_collector_if #(
    parameter int unsigned RAY_SLOTS = 16,
    parameter int unsigned FP_W      = 32,
    parameter int unsigned PRIM_W    = 24
);
    localparam int unsigned RAY_W = $clog2(RAY_SLOTS);

    // Ray start
    logic              init_valid;
    logic              init_ready;
    logic [RAY_W-1:0]  init_ray;
    logic [FP_W-1:0]   init_tmax;

    // Ray-triangle results
    logic              res_valid;
    logic              res_ready;
    logic [RAY_W-1:0]  res_ray;
    logic [FP_W-1:0]   res_t;
    logic [FP_W-1:0]   res_u;
    logic [FP_W-1:0]   res_v;
    logic [PRIM_W-1:0] res_prim;
    logic              res_hit;

    // Traversal complete
    logic              done_valid;
    logic              done_ready;
    logic [RAY_W-1:0]  done_ray;

    // Hit record toward shader dispatch
    logic              out_valid;
    logic              out_ready;
    logic [RAY_W-1:0]  out_ray;
    logic [FP_W-1:0]   out_t;
    logic [FP_W-1:0]   out_u;
    logic [FP_W-1:0]   out_v;
    logic [PRIM_W-1:0] out_prim;
    logic              out_hit;
    logic              out_err;

    // Culling query and statistics
    logic [RAY_W-1:0]  q_ray;
    logic [FP_W-1:0]   q_tmax;
    logic [7:0]        drop_cnt;

    modport slave (
        input  init_valid, init_ray, init_tmax,
        output init_ready,
        input  res_valid, res_ray, res_t, res_u, res_v, res_prim, res_hit,
        output res_ready,
        input  done_valid, done_ray,
        output done_ready,
        output out_valid, out_ray, out_t, out_u, out_v, out_prim, out_hit, out_err,
        input  out_ready,
        input  q_ray,
        output q_tmax, drop_cnt
    );

    modport master (
        output init_valid, init_ray, init_tmax,
        input  init_ready,
        output res_valid, res_ray, res_t, res_u, res_v, res_prim, res_hit,
        input  res_ready,
        output done_valid, done_ray,
        input  done_ready,
        input  out_valid, out_ray, out_t, out_u, out_v, out_prim, out_hit, out_err,
        output out_ready,
        output q_ray,
        input  q_tmax, drop_cnt
    );
endinterface

// File: rtl/closest_hit_collector.sv
// Closest-hit collector: keeps the nearest accepted hit per in-flight ray and emits one
// hit record per ray through a single-entry output register when traversal completes.
module closest_hit_collector #(
    parameter int unsigned RAY_SLOTS = 16,
    parameter int unsigned FP_W      = 32,
    parameter int unsigned PRIM_W    = 24
) (
    input logic                    clk,
    input logic                    rst,
    closest_hit_collector_if.slave bus_io
);
    localparam int unsigned RAY_W = $clog2(RAY_SLOTS);

    // Per-slot control state (reset) and payload (not reset)
    logic [RAY_SLOTS-1:0] active_q, active_d;
    logic [RAY_SLOTS-1:0] has_hit_q, has_hit_d;
    logic [FP_W-1:0]      best_t_q    [RAY_SLOTS];
    logic [FP_W-1:0]      best_t_d    [RAY_SLOTS];
    logic [FP_W-1:0]      best_u_q    [RAY_SLOTS];
    logic [FP_W-1:0]      best_u_d    [RAY_SLOTS];
    logic [FP_W-1:0]      best_v_q    [RAY_SLOTS];
    logic [FP_W-1:0]      best_v_d    [RAY_SLOTS];
    logic [PRIM_W-1:0]    best_prim_q [RAY_SLOTS];
    logic [PRIM_W-1:0]    best_prim_d [RAY_SLOTS];

    // Output record register
    logic              out_valid_q, out_valid_d;
    logic [RAY_W-1:0]  out_ray_q, out_ray_d;
    logic [FP_W-1:0]   out_t_q, out_t_d;
    logic [FP_W-1:0]   out_u_q, out_u_d;
    logic [FP_W-1:0]   out_v_q, out_v_d;
    logic [PRIM_W-1:0] out_prim_q, out_prim_d;
    logic              out_hit_q, out_hit_d;
    logic              out_err_q, out_err_d;

    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic [FP_W-1:0]   q_tmax_q, q_tmax_d;

    logic init_fire, res_fire, done_fire;
    logic res_active, res_better, res_take, res_drop;
    logic done_active, done_bypass;

    assign bus_io.init_ready = ~rst & ~active_q[bus_io.init_ray];
    assign bus_io.res_ready  = ~rst;
    assign bus_io.done_ready = ~rst & (~out_valid_q | bus_io.out_ready);

    assign init_fire = bus_io.init_valid & bus_io.init_ready;
    assign res_fire  = bus_io.res_valid & bus_io.res_ready;
    assign done_fire = bus_io.done_valid & bus_io.done_ready;

    // FP32 values with the sign clear order like unsigned integers, so a plain compare works.
    // Strict less-than keeps the earlier hit on a tie.
    assign res_active = active_q[bus_io.res_ray];
    assign res_better = bus_io.res_t < best_t_q[bus_io.res_ray];
    assign res_take   = res_fire & res_active & bus_io.res_hit & ~bus_io.res_t[FP_W-1]
                        & res_better;
    assign res_drop   = res_fire & ~res_active;

    assign done_active = active_q[bus_io.done_ray];
    assign done_bypass = res_take & (bus_io.res_ray == bus_io.done_ray);

    // Slot control next state; done clears before init sets so an init on a freed slot wins
    always_comb begin
        active_d  = active_q;
        has_hit_d = has_hit_q;
        if (res_take) begin
            has_hit_d[bus_io.res_ray] = 1'b1;
        end
        if (done_fire) begin
            active_d[bus_io.done_ray] = 1'b0;
        end
        if (init_fire) begin
            active_d[bus_io.init_ray]  = 1'b1;
            has_hit_d[bus_io.init_ray] = 1'b0;
        end
    end

    // Slot payload next state; init and a taken result never hit the same slot
    always_comb begin
        best_t_d    = best_t_q;
        best_u_d    = best_u_q;
        best_v_d    = best_v_q;
        best_prim_d = best_prim_q;
        if (res_take) begin
            best_t_d[bus_io.res_ray]    = bus_io.res_t;
            best_u_d[bus_io.res_ray]    = bus_io.res_u;
            best_v_d[bus_io.res_ray]    = bus_io.res_v;
            best_prim_d[bus_io.res_ray] = bus_io.res_prim;
        end
        if (init_fire) begin
            best_t_d[bus_io.init_ray] = bus_io.init_tmax;
        end
    end

    // Output record capture, with bypass of a same-cycle winning result
    always_comb begin
        out_valid_d = out_valid_q;
        out_ray_d   = out_ray_q;
        out_t_d     = out_t_q;
        out_u_d     = out_u_q;
        out_v_d     = out_v_q;
        out_prim_d  = out_prim_q;
        out_hit_d   = out_hit_q;
        out_err_d   = out_err_q;
        if (done_fire) begin
            out_valid_d = 1'b1;
            out_ray_d   = bus_io.done_ray;
            if (!done_active) begin
                out_t_d    = '0;
                out_u_d    = '0;
                out_v_d    = '0;
                out_prim_d = '0;
                out_hit_d  = 1'b0;
                out_err_d  = 1'b1;
            end else if (done_bypass) begin
                out_t_d    = bus_io.res_t;
                out_u_d    = bus_io.res_u;
                out_v_d    = bus_io.res_v;
                out_prim_d = bus_io.res_prim;
                out_hit_d  = 1'b1;
                out_err_d  = 1'b0;
            end else begin
                out_t_d    = best_t_q[bus_io.done_ray];
                out_u_d    = best_u_q[bus_io.done_ray];
                out_v_d    = best_v_q[bus_io.done_ray];
                out_prim_d = best_prim_q[bus_io.done_ray];
                out_hit_d  = has_hit_q[bus_io.done_ray];
                out_err_d  = 1'b0;
            end
        end else if (bus_io.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Saturating drop counter and registered culling query
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (res_drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
        q_tmax_d = best_t_q[bus_io.q_ray];
    end

    // Control, output and statistics registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q    <= '0;
            has_hit_q   <= '0;
            out_valid_q <= 1'b0;
            out_ray_q   <= '0;
            out_t_q     <= '0;
            out_u_q     <= '0;
            out_v_q     <= '0;
            out_prim_q  <= '0;
            out_hit_q   <= 1'b0;
            out_err_q   <= 1'b0;
            drop_cnt_q  <= '0;
            q_tmax_q    <= '0;
        end else begin
            active_q    <= active_d;
            has_hit_q   <= has_hit_d;
            out_valid_q <= out_valid_d;
            out_ray_q   <= out_ray_d;
            out_t_q     <= out_t_d;
            out_u_q     <= out_u_d;
            out_v_q     <= out_v_d;
            out_prim_q  <= out_prim_d;
            out_hit_q   <= out_hit_d;
            out_err_q   <= out_err_d;
            drop_cnt_q  <= drop_cnt_d;
            q_tmax_q    <= q_tmax_d;
        end
    end

    // Slot payload storage; only meaningful while the slot is active, so left unreset
    always_ff @(posedge clk) begin
        best_t_q    <= best_t_d;
        best_u_q    <= best_u_d;
        best_v_q    <= best_v_d;
        best_prim_q <= best_prim_d;
    end

    assign bus_io.out_valid = out_valid_q;
    assign bus_io.out_ray   = out_ray_q;
    assign bus_io.out_t     = out_t_q;
    assign bus_io.out_u     = out_u_q;
    assign bus_io.out_v     = out_v_q;
    assign bus_io.out_prim  = out_prim_q;
    assign bus_io.out_hit   = out_hit_q;
    assign bus_io.out_err   = out_err_q;
    assign bus_io.drop_cnt  = drop_cnt_q;
    assign bus_io.q_tmax    = q_tmax_q;

endmodule

// File: tb/tb_closest_hit_collector.sv
// Directed bench for closest_hit_collector with hand-computed expected records.
module tb_closest_hit_collector;
    localparam int unsigned RAY_SLOTS = 16;
    localparam int unsigned FP_W      = 32;
    localparam int unsigned PRIM_W    = 24;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    closest_hit_collector_if #(
        .RAY_SLOTS(RAY_SLOTS),
        .FP_W     (FP_W),
        .PRIM_W   (PRIM_W)
    ) bus ();

    closest_hit_collector #(
        .RAY_SLOTS(RAY_SLOTS),
        .FP_W     (FP_W),
        .PRIM_W   (PRIM_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_init(input logic [3:0] ray, input logic [31:0] tmax);
        bus.init_valid = 1'b1;
        bus.init_ray   = ray;
        bus.init_tmax  = tmax;
        step();
        bus.init_valid = 1'b0;
    endtask

    task automatic set_res(input logic [3:0] ray, input logic [31:0] t,
                           input logic [23:0] prim, input logic hit);
        bus.res_valid = 1'b1;
        bus.res_ray   = ray;
        bus.res_t     = t;
        bus.res_u     = 32'h3E00_0000 | 32'(prim);
        bus.res_v     = 32'h3F00_0000 | 32'(prim);
        bus.res_prim  = prim;
        bus.res_hit   = hit;
    endtask

    task automatic do_res(input logic [3:0] ray, input logic [31:0] t,
                          input logic [23:0] prim, input logic hit);
        set_res(ray, t, prim, hit);
        step();
        bus.res_valid = 1'b0;
    endtask

    task automatic do_done(input logic [3:0] ray);
        bus.done_valid = 1'b1;
        bus.done_ray   = ray;
        step();
        bus.done_valid = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.init_valid = 1'b0;
        bus.init_ray   = '0;
        bus.init_tmax  = '0;
        bus.res_valid  = 1'b0;
        bus.res_ray    = '0;
        bus.res_t      = '0;
        bus.res_u      = '0;
        bus.res_v      = '0;
        bus.res_prim   = '0;
        bus.res_hit    = 1'b0;
        bus.done_valid = 1'b0;
        bus.done_ray   = '0;
        bus.out_ready  = 1'b1;
        bus.q_ray      = 4'd3;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_out_hit", 64'(bus.out_hit), 64'd0);
        check_eq("rst_out_err", 64'(bus.out_err), 64'd0);
        check_eq("rst_drop_cnt", 64'(bus.drop_cnt), 64'd0);
        check_eq("rst_q_tmax", 64'(bus.q_tmax), 64'd0);
        rst = 1'b0;
        step();
        check_eq("res_ready", 64'(bus.res_ready), 64'd1);
        check_eq("done_ready_idle", 64'(bus.done_ready), 64'd1);
        bus.init_ray = 4'd3;
        #1;
        check_eq("init_ready_idle", 64'(bus.init_ready), 64'd1);

        // Closest of three hits, with one-cycle q_tmax latency
        do_init(4'd3, 32'h42C8_0000);
        do_res(4'd3, 32'h4120_0000, 24'd7, 1'b1);
        check_eq("q_tmax_init", 64'(bus.q_tmax), 64'h42C8_0000);
        do_res(4'd3, 32'h40A0_0000, 24'd9, 1'b1);
        check_eq("q_tmax_lag", 64'(bus.q_tmax), 64'h4120_0000);
        do_res(4'd3, 32'h4100_0000, 24'd2, 1'b1);
        check_eq("q_tmax_best", 64'(bus.q_tmax), 64'h40A0_0000);
        do_done(4'd3);
        check_eq("s1_out_valid", 64'(bus.out_valid), 64'd1);
        check_eq("s1_out_ray", 64'(bus.out_ray), 64'd3);
        check_eq("s1_out_t", 64'(bus.out_t), 64'h40A0_0000);
        check_eq("s1_out_u", 64'(bus.out_u), 64'h3E00_0009);
        check_eq("s1_out_prim", 64'(bus.out_prim), 64'd9);
        check_eq("s1_out_hit", 64'(bus.out_hit), 64'd1);
        check_eq("s1_out_err", 64'(bus.out_err), 64'd0);
        check_eq("s1_init_ready_freed", 64'(bus.init_ready), 64'd1);
        step();
        check_eq("s1_drained", 64'(bus.out_valid), 64'd0);

        // Miss beyond tmax
        do_init(4'd0, 32'h3F80_0000);
        do_res(4'd0, 32'h4000_0000, 24'd5, 1'b1);
        do_done(4'd0);
        check_eq("s2_out_hit", 64'(bus.out_hit), 64'd0);
        check_eq("s2_out_t", 64'(bus.out_t), 64'h3F80_0000);
        check_eq("s2_out_err", 64'(bus.out_err), 64'd0);
        step();

        // Negative t and res_hit=0 ignored even though they compare below tmax
        do_init(4'd4, 32'hFFFF_FFFF);
        do_res(4'd4, 32'hBF80_0000, 24'd1, 1'b1);
        do_res(4'd4, 32'h4000_0000, 24'd2, 1'b0);
        do_done(4'd4);
        check_eq("neg_out_hit", 64'(bus.out_hit), 64'd0);
        check_eq("neg_out_t", 64'(bus.out_t), 64'hFFFF_FFFF);
        check_eq("neg_no_drop", 64'(bus.drop_cnt), 64'd0);
        step();

        // Drops to an inactive slot saturate at 255
        set_res(4'd5, 32'h3F80_0000, 24'd3, 1'b1);
        repeat (254) step();
        check_eq("drop_254", 64'(bus.drop_cnt), 64'd254);
        step();
        check_eq("drop_255", 64'(bus.drop_cnt), 64'd255);
        repeat (45) step();
        bus.res_valid = 1'b0;
        check_eq("drop_sat", 64'(bus.drop_cnt), 64'd255);
        do_done(4'd5);
        check_eq("s3_out_err", 64'(bus.out_err), 64'd1);
        check_eq("s3_out_hit", 64'(bus.out_hit), 64'd0);
        check_eq("s3_out_t", 64'(bus.out_t), 64'd0);
        check_eq("s3_out_ray", 64'(bus.out_ray), 64'd5);
        step();

        // Back-pressure holds the pending record and refuses done
        do_init(4'd1, 32'h41A0_0000);
        bus.out_ready = 1'b0;
        do_done(4'd6);
        bus.done_valid = 1'b1;
        bus.done_ray   = 4'd1;
        #1;
        check_eq("bp_done_ready", 64'(bus.done_ready), 64'd0);
        repeat (3) step();
        check_eq("bp_held_valid", 64'(bus.out_valid), 64'd1);
        check_eq("bp_held_ray", 64'(bus.out_ray), 64'd6);
        check_eq("bp_held_err", 64'(bus.out_err), 64'd1);
        bus.out_ready = 1'b1;
        #1;
        check_eq("bp_done_ready_up", 64'(bus.done_ready), 64'd1);
        step();
        bus.done_valid = 1'b0;
        check_eq("bp_new_valid", 64'(bus.out_valid), 64'd1);
        check_eq("bp_new_ray", 64'(bus.out_ray), 64'd1);
        check_eq("bp_new_err", 64'(bus.out_err), 64'd0);
        check_eq("bp_new_t", 64'(bus.out_t), 64'h41A0_0000);
        step();
        check_eq("bp_drained", 64'(bus.out_valid), 64'd0);

        // Same-cycle result bypass into done; same-ray init refused then accepted
        do_init(4'd2, 32'h42C8_0000);
        do_res(4'd2, 32'h4080_0000, 24'd20, 1'b1);
        set_res(4'd2, 32'h4040_0000, 24'd21, 1'b1);
        bus.done_valid = 1'b1;
        bus.done_ray   = 4'd2;
        bus.init_valid = 1'b1;
        bus.init_ray   = 4'd2;
        bus.init_tmax  = 32'h4100_0000;
        #1;
        check_eq("byp_init_refused", 64'(bus.init_ready), 64'd0);
        step();
        bus.res_valid  = 1'b0;
        bus.done_valid = 1'b0;
        #1;
        check_eq("byp_out_t", 64'(bus.out_t), 64'h4040_0000);
        check_eq("byp_out_prim", 64'(bus.out_prim), 64'd21);
        check_eq("byp_out_hit", 64'(bus.out_hit), 64'd1);
        check_eq("byp_init_ready_next", 64'(bus.init_ready), 64'd1);
        step();
        bus.init_valid = 1'b0;
        #1;
        check_eq("byp_init_taken", 64'(bus.init_ready), 64'd0);
        do_done(4'd2);
        check_eq("byp_reinit_t", 64'(bus.out_t), 64'h4100_0000);
        check_eq("byp_reinit_hit", 64'(bus.out_hit), 64'd0);
        step();

        // Tie keeps the earlier hit
        do_init(4'd7, 32'h42C8_0000);
        do_res(4'd7, 32'h40C0_0000, 24'd11, 1'b1);
        do_res(4'd7, 32'h40C0_0000, 24'd12, 1'b1);
        do_done(4'd7);
        check_eq("tie_out_prim", 64'(bus.out_prim), 64'd11);
        check_eq("tie_out_t", 64'(bus.out_t), 64'h40C0_0000);
        step();

        // Reset mid-operation discards the pending record and active slots
        do_init(4'd8, 32'h3F80_0000);
        bus.out_ready = 1'b0;
        do_done(4'd9);
        check_eq("mr_pending", 64'(bus.out_valid), 64'd1);
        do_init(4'd10, 32'h3F80_0000);
        rst = 1'b1;
        #1;
        check_eq("mr_valid_in_rst", 64'(bus.out_valid), 64'd0);
        check_eq("mr_drop_in_rst", 64'(bus.drop_cnt), 64'd0);
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) step();
        check_eq("mr_no_pulse", 64'(bus.out_valid), 64'd0);
        bus.init_ray = 4'd10;
        #1;
        check_eq("mr_slot_freed", 64'(bus.init_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/closest_hit_collector.md
CLOSEST_HIT_COLLECTOR -- requirements
Module: closest_hit_collector

Interface
REQ-001 SHALL have parameter RAY_SLOTS, default 16: number of in-flight ray entries, a power of two.
REQ-002 SHALL have parameter FP_W, default 32: width of the FP32 t/u/v fields.
REQ-003 SHALL have parameter PRIM_W, default 24: width of the primitive ID.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: asynchronous active-high reset.
REQ-006 Ports init_valid/init_ready, in/out, 1 each: ray-start handshake; init_ray in, log2(RAY_SLOTS); init_tmax in, FP_W.
REQ-007 Ports res_valid/res_ready, in/out, 1 each: ray-triangle result stream; res_ray in, log2(RAY_SLOTS); res_t/res_u/res_v in, FP_W; res_prim in, PRIM_W; res_hit in, 1.
REQ-008 Ports done_valid/done_ready, in/out, 1 each: traversal-complete handshake; done_ray in, log2(RAY_SLOTS).
REQ-009 Ports out_valid out, 1; out_ready in, 1: hit-record handshake toward shader dispatch.
REQ-010 Record ports, all out: out_ray, log2(RAY_SLOTS); out_t/out_u/out_v, FP_W; out_prim, PRIM_W; out_hit, 1; out_err, 1.
REQ-011 Query ports: q_ray in, log2(RAY_SLOTS); q_tmax out, FP_W, current closest t fed back to traversal culling.
REQ-012 Port drop_cnt, out, 8: count of results dropped for inactive slots, saturating at 255.

Function
REQ-013 Each slot SHALL hold active, best_t, best_u, best_v, best_prim and has_hit.
REQ-014 init_ready SHALL equal !active[init_ray]; an accepted init sets active=1, best_t=init_tmax, has_hit=0.
REQ-015 res_ready SHALL be constantly 1 outside reset.
REQ-016 An accepted result SHALL update its slot only when all hold: active=1, res_hit=1, res_t[FP_W-1]=0, and res_t < best_t as an unsigned bit-compare. An update writes t, u, v and prim, and sets has_hit=1.
REQ-017 An equal t (tie) SHALL NOT update the slot; the earlier hit wins.
REQ-018 A result arriving for a slot with active=0 SHALL be discarded and increment drop_cnt by 1, saturating at 255.
REQ-019 A result with res_hit=0 or a negative t SHALL be ignored silently.
REQ-020 done_ready SHALL equal !out_valid || out_ready, forming a one-entry output register.
REQ-021 On done accept in cycle N, the slot contents SHALL be captured into the out_* registers and out_valid SHALL assert in cycle N+1. The same cycle clears active.
REQ-022 If a qualifying result for the same ray is accepted in the same cycle as done, the captured record SHALL include that result (bypass).
REQ-023 A done for an inactive slot SHALL emit out_hit=0, out_err=1, out_t=out_u=out_v=0 and out_prim=0.
REQ-024 For a valid record, out_hit SHALL equal has_hit and out_err SHALL be 0; out_t SHALL equal init_tmax when there is no hit.
REQ-025 out_* signals SHALL be held stable while out_valid=1 and out_ready=0.
REQ-026 q_tmax SHALL be registered with 1-cycle latency and equal best_t[q_ray]; the value includes updates from the previous cycle, with no same-cycle bypass.
REQ-027 When init and done target the same ray in one cycle, init SHALL be refused because the slot is still active, and accepted in the following cycle.
REQ-028 Results, init and done targeting different slots in the same cycle SHALL all take effect independently.

Reset
REQ-029 While rst=1, all active bits, has_hit bits, out_valid, out_err, out_hit, drop_cnt and q_tmax SHALL be 0.
REQ-030 Reset asserted mid-operation SHALL discard in-flight records; no out_valid pulse is emitted after reset release until a new done is accepted.
REQ-031 Slot payload fields (t, u, v, prim) need not be reset.

Verification
REQ-032 Scenario: init ray 3 with tmax=0x42C80000 (100.0), then results t=0x41200000 (10.0) prim 7, t=0x40A00000 (5.0) prim 9, and t=0x41000000 (8.0) prim 2, then done 3 -> out_ray=3, out_t=0x40A00000, out_prim=9, out_hit=1, out_err=0.
REQ-033 Scenario: init ray 0 with tmax=1.0, a result with t=2.0, then done -> out_hit=0, out_t=0x3F800000.
REQ-034 Scenario: a result for inactive ray 5 repeated 300 times -> drop_cnt=255; done for ray 5 -> out_err=1.
REQ-035 Scenario: hold out_ready=0 with a record pending, then assert done for ray 1 -> done_ready=0 and the record is held stable; raise out_ready -> done is accepted that cycle.
REQ-036 Scenario: a same-cycle result t=3.0 and done for active ray 2 whose best_t=4.0 -> out_t=0x40400000; an init for ray 2 in the same cycle is refused and accepted in the next cycle.
REQ-037 Scenario: two results with equal t=6.0 and prims 11 then 12 -> out_prim=11.
